mxint_block_accumulator: RTL

Streaming MXINT accumulator that sits directly downstream of the MXINT ReLU/cast stage and sums `BLOCK_NUM` consecutive MXINT blocks lane-by-lane into one wider MXINT block. It is used for pooling and partial-sum reduction. Exponents are aligned on the fly to the running maximum, and mantissas are shifted arithmetically. The result is emitted through a single registered output slot with valid/ready backpressure.

---
 rtl/mxint_block_accumulator.sv | 73 +++++++
 1 files changed

// File: rtl/mxint_block_accumulator.sv
// mxint_block_accumulator: sums BLOCK_NUM MXINT blocks lane-wise, aligning exponents to the running max
module mxint_block_accumulator #(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int BLOCK_NUM = 4,
    localparam int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + $clog2(BLOCK_NUM),
    localparam int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1
) (
    input  logic clk,
    input  logic rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0] mdata_in_0 [BLOCK_SIZE],
    input  logic [DATA_IN_0_PRECISION_1-1:0] edata_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic signed [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE],
    output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready
);
    localparam int EW = DATA_IN_0_PRECISION_1;
    localparam int OW = DATA_OUT_0_PRECISION_0;
    localparam int CW = BLOCK_NUM > 1 ? $clog2(BLOCK_NUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_NUM - 1);
    logic [CW-1:0] cnt;
    logic signed [OW-1:0] acc [BLOCK_SIZE];
    logic signed [OW-1:0] ext [BLOCK_SIZE];
    logic signed [OW-1:0] nxt [BLOCK_SIZE];
    logic [EW-1:0] acc_exp;
    logic [EW-1:0] nxt_exp;
    logic [EW-1:0] d;
    logic first;
    logic last;
    logic up;
    logic beat;
    assign last = cnt == LAST;
    assign beat = data_in_0_valid && data_in_0_ready;
    assign data_in_0_ready = !last || !data_out_0_valid || data_out_0_ready;
    // the operand with the smaller exponent is shifted; >>> past OW bits yields pure sign fill
    always_comb begin
        first = cnt == '0;
        up = !first && edata_in_0 > acc_exp;
        d = up ? edata_in_0 - acc_exp : acc_exp - edata_in_0;
        nxt_exp = first || up ? edata_in_0 : acc_exp;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            ext[i] = OW'(mdata_in_0[i]);
            nxt[i] = first ? ext[i] : up ? (acc[i] >>> d) + ext[i] : acc[i] + (ext[i] >>> d);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc_exp <= '0;
            edata_out_0 <= '0;
            data_out_0_valid <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                acc[i] <= '0;
                mdata_out_0[i] <= '0;
            end
        end else begin
            if (beat && last) begin
                mdata_out_0 <= nxt;
                edata_out_0 <= nxt_exp;
                cnt <= '0;
            end else if (beat) begin
                acc <= nxt;
                acc_exp <= nxt_exp;
                cnt <= cnt + CW'(1);
            end
            data_out_0_valid <= beat && last ? 1'b1 : data_out_0_ready ? 1'b0 : data_out_0_valid;
        end
    end
endmodule
